// File: rtl/change_dispenser_if.sv
// Request/sensor inputs and hopper/status outputs of the coin-return back end.
interface change_dispenser_if;
  logic [1:0] chg_cnt;
  logic       coin_sense;
  logic       eject;
  logic       busy;
  logic       fault;
  logic       ovf;
  logic       spur;
  logic [7:0] coins_out;

  modport master (
    output chg_cnt, coin_sense,
    input  eject, busy, fault, ovf, spur, coins_out
  );

  modport slave (
    input  chg_cnt, coin_sense,
    output eject, busy, fault, ovf, spur, coins_out
  );
endinterface

// File: rtl/change_dispenser.sv
// Queues change requests and ejects one coin per pulse, confirming each with the drop sensor.
// First eject two cycles after a request; requests arriving at a full FIFO are dropped and flagged.
module change_dispenser #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 4,
  parameter int TIMEOUT = 64,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  change_dispenser_if.slave bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (TIMEOUT > PULSE_W) ? ((TIMEOUT > GAP_W) ? TIMEOUT : GAP_W)
                                            : ((PULSE_W > GAP_W) ? PULSE_W : GAP_W);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] P_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_W - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EJECT = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          got_q, got_d;
  logic [1:0]    remain_q, remain_d;
  logic [AW:0]   wptr_q, rptr_q;
  logic [1:0]    mem_q [DEPTH];
  logic          eject_q, fault_q, ovf_q, spur_q;
  logic [7:0]    coins_q;

  logic empty, full, pop, push_req, push, drop, count_coin, spur_set, got_now;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop      = (state_q == S_IDLE) && !empty;
  assign push_req = (bus.chg_cnt != 2'd0);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign spur_set = bus.coin_sense &&
                    ((state_q == S_IDLE) || (state_q == S_GAP) || (state_q == S_FAULT));
  assign got_now  = got_q || bus.coin_sense;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    got_d      = got_q;
    remain_d   = remain_q;
    count_coin = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d  = S_EJECT;
          cnt_d    = '0;
          got_d    = 1'b0;
          remain_d = mem_q[rptr_q[AW-1:0]];
        end
      end
      S_EJECT: begin
        if (cnt_q == P_LAST) begin
          got_d = 1'b0;
          if (got_now) begin
            count_coin = 1'b1;
            state_d    = S_GAP;
            cnt_d      = '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = C_ONE;
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
          got_d = got_now;
        end
      end
      S_WAIT: begin
        // A sensor pulse in the final counted cycle still beats the timeout.
        if (bus.coin_sense) begin
          count_coin = 1'b1;
          state_d    = S_GAP;
          cnt_d      = '0;
        end else if (cnt_q == T_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == G_LAST) begin
          state_d = (remain_q != 2'd0) ? S_EJECT : S_IDLE;
          cnt_d   = '0;
          got_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (count_coin) begin
      remain_d = remain_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      got_q    <= 1'b0;
      remain_q <= 2'd0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      eject_q  <= 1'b0;
      fault_q  <= 1'b0;
      ovf_q    <= 1'b0;
      spur_q   <= 1'b0;
      coins_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      got_q    <= got_d;
      remain_q <= remain_d;
      eject_q  <= (state_d == S_EJECT);
      fault_q  <= (state_d == S_FAULT);
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
      if (spur_set) begin
        spur_q <= 1'b1;
      end
      if (count_coin) begin
        coins_q <= coins_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= bus.chg_cnt;
    end
  end

  assign bus.eject     = eject_q;
  assign bus.busy      = (state_q != S_IDLE) || !empty;
  assign bus.fault     = fault_q;
  assign bus.ovf       = ovf_q;
  assign bus.spur      = spur_q;
  assign bus.coins_out = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed and randomized checks of change_dispenser against a coin-count/queue-occupancy model.
module tb_change_dispenser;
  localparam int PW = 4;
  localparam int GW = 4;
  localparam int TO = 64;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   model_coins = 0;

  change_dispenser_if bus();

  change_dispenser #(.PULSE_W(PW), .GAP_W(GW), .TIMEOUT(TO), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [127:0] rng(input int lo, input int hi);
    logic [127:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [127:0] bit_at(input int a);
    logic [127:0] r;
    r = '0;
    r[a] = 1'b1;
    return r;
  endfunction

  task automatic push(input logic [1:0] v);
    bus.chg_cnt = v;
    tick();
    bus.chg_cnt = 2'd0;
  endtask

  // Cycle 0 is the current cycle; sample outputs of cycles 1..ncyc, drive masked inputs per cycle.
  task automatic watch(input int ncyc, input logic [1:0] v, input logic [127:0] pmask,
                       input logic [127:0] smask, output logic [127:0] ej,
                       output logic [127:0] ft, output logic [127:0] bz);
    ej = '0; ft = '0; bz = '0;
    bus.chg_cnt    = pmask[0] ? v : 2'd0;
    bus.coin_sense = smask[0];
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      ej[c] = bus.eject;
      ft[c] = bus.fault;
      bz[c] = bus.busy;
      bus.chg_cnt    = pmask[c] ? v : 2'd0;
      bus.coin_sense = smask[c];
    end
  endtask

  // Hopper model: one sensor pulse a random delay after each eject rise; runs until idle.
  task automatic serve(input int budget, input int maxd);
    int   cd;
    int   width;
    logic prev;
    logic done;
    cd = -1; width = 0; prev = 1'b0; done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      bus.chg_cnt    = 2'd0;
      bus.coin_sense = 1'b0;
      if (bus.eject && !prev) begin
        cd    = $urandom_range(maxd, 0);
        width = 0;
      end
      if (bus.eject) width++;
      if (!bus.eject && prev) check("pulse_width", width, PW);
      if (cd == 0) bus.coin_sense = 1'b1;
      if (cd >= 0) cd--;
      prev = bus.eject;
      if (!bus.busy && !bus.eject) done = 1'b1;
    end
    check("serve_done", done, 1'b1);
    bus.coin_sense = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_eject"}, bus.eject, 1'b0);
    check({tag, "_busy"},  bus.busy,  1'b0);
    check({tag, "_fault"}, bus.fault, 1'b0);
    check({tag, "_ovf"},   bus.ovf,   1'b0);
    check({tag, "_spur"},  bus.spur,  1'b0);
    check({tag, "_coins"}, bus.coins_out, 8'd0);
  endtask

  initial begin
    logic [127:0] ej, ft, bz;
    int   msz;
    logic movf;
    logic [1:0] v;

    bus.chg_cnt = 2'd0;
    bus.coin_sense = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    check_idle_outputs("reset");
    rst = 1'b1;
    tick();

    // Two coins, sensor during each pulse: 4 high, 4 low, 4 high.
    watch(20, 2'd2, bit_at(0), bit_at(3) | bit_at(11), ej, ft, bz);
    check("single_eject", ej, rng(2, 5) | rng(10, 13));
    check("single_busy", bz & rng(1, 20), rng(1, 17));
    model_coins = 2;
    check("single_coins", bus.coins_out, model_coins);
    check("single_fault", bus.fault, 1'b0);
    check("single_ovf", bus.ovf, 1'b0);
    check("single_spur", bus.spur, 1'b0);

    // Sensor 10 cycles after the pulse ends: exits WAIT, no fault.
    watch(25, 2'd1, bit_at(0), bit_at(16), ej, ft, bz);
    check("late_eject", ej, rng(2, 5));
    check("late_busy", bz & rng(1, 25), rng(1, 20));
    model_coins += 1;
    check("late_coins", bus.coins_out, model_coins);
    check("late_fault", bus.fault, 1'b0);

    // No sensor: WAIT counts 1..TO over cycles 6..69, fault visible from cycle 70.
    watch(75, 2'd1, bit_at(0), '0, ej, ft, bz);
    check("timeout_eject", ej, rng(2, 5));
    check("timeout_fault", ft, rng(6 + TO, 75));
    msz = 0; movf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(2'd2);
      if (msz < DP) msz++; else movf = 1'b1;
      check("fault_ovf", bus.ovf, movf);
    end
    watch(30, 2'd0, '0, '0, ej, ft, bz);
    check("fault_no_eject", ej, '0);
    check("fault_busy", bz & rng(1, 30), rng(1, 30));
    check("fault_coins", bus.coins_out, model_coins);

    rst = 1'b0;
    #1;
    check_idle_outputs("reset_fault");
    tick();
    rst = 1'b1;
    tick();
    model_coins = 0;

    // Sensor with nothing ejecting.
    bus.coin_sense = 1'b1;
    tick();
    bus.coin_sense = 1'b0;
    tick();
    check("spur_flag", bus.spur, 1'b1);
    check("spur_coins", bus.coins_out, model_coins);
    check("spur_busy", bus.busy, 1'b0);

    // Reset in the middle of a pulse.
    push(2'd1);
    tick();
    tick();
    check("mid_pulse_eject", bus.eject, 1'b1);
    rst = 1'b0;
    #1;
    check_idle_outputs("reset_mid");
    tick();
    rst = 1'b1;
    tick();
    push(2'd1);
    serve(300, PW + 20);
    model_coins = 1;
    check("after_reset_coins", bus.coins_out, model_coins);
    check("after_reset_fault", bus.fault, 1'b0);
    check("after_reset_spur", bus.spur, 1'b0);

    // Overflow: five pushes of 3 while the first request's pulse is active.
    push(2'd3);
    tick();
    msz = 0; movf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.chg_cnt = 2'd3;
      bus.coin_sense = (i == 1);
      tick();
      if (msz < DP) msz++; else movf = 1'b1;
    end
    bus.chg_cnt = 2'd0;
    bus.coin_sense = 1'b0;
    check("ovf_flag", bus.ovf, movf);
    serve(1500, PW + 20);
    model_coins = (model_coins + 3 + 3 * msz) % 256;
    check("ovf_coins", bus.coins_out, model_coins);
    check("ovf_fault", bus.fault, 1'b0);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    model_coins = 0;

    // Fill the FIFO behind a one-coin request, then push exactly in the IDLE pop cycle.
    watch(10, 2'd1, bit_at(0) | rng(2, 5) | bit_at(10), bit_at(3), ej, ft, bz);
    check("pp_eject", ej, rng(2, 5));
    serve(600, PW + 20);
    check("pp_ovf", bus.ovf, 1'b0);
    model_coins = 1 + 4 + 1;
    check("pp_coins", bus.coins_out, model_coins);

    // Random request sizes and sensor timing.
    for (int i = 0; i < 20; i++) begin
      v = 2'($urandom_range(3, 1));
      push(v);
      serve(400, PW + 20);
      model_coins = (model_coins + int'(v)) % 256;
      check("rand_coins", bus.coins_out, model_coins);
      check("rand_fault", bus.fault, 1'b0);
    end
    check("rand_spur", bus.spur, 1'b0);
    check("rand_ovf", bus.ovf, 1'b0);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    model_coins = 0;

    // 86 requests of 3 coins wrap the counter to 2.
    for (int i = 0; i < 86; i++) begin
      push(2'd3);
      serve(400, PW + 12);
      model_coins = (model_coins + 3) % 256;
      check("wrap_coins", bus.coins_out, model_coins);
    end
    check("wrap_final", bus.coins_out, 8'd2);
    check("wrap_fault", bus.fault, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
